// File: rtl/post_cn_hash_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : post_cn_hash_dispatch
// Brief    : Streams a buffered Keccak state into the selected finalist core
//            and returns result, nonce and hash type on one ready/valid port.
//            Optional share-target filter: POST_CN_TARGET_FILTER_EN.
// Revision : 1.0
// ============================================================================
module post_cn_hash_dispatch #(
    parameter int STATE_WIDTH  = 1600,
    parameter int NONCE_WIDTH  = 7,
    parameter int MSG_WORDS    = 25,
    parameter int RESULT_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [STATE_WIDTH-1:0]     i_state,
    input  logic [NONCE_WIDTH-1:0]     i_nonce,
    output logic [1:0]                 o_hash_sel,
    output logic [63:0]                o_core_din,
    output logic                       o_core_din_valid,
    input  logic                       i_core_din_read,
    input  logic [63:0]                i_core_dout,
    input  logic                       i_core_dout_write,
    output logic                       o_core_dout_ready,
`ifdef POST_CN_TARGET_FILTER_EN
    input  logic [63:0]                i_target,
    output logic [31:0]                o_drop_count,
`endif
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [RESULT_WORDS*64-1:0] o_result,
    output logic [NONCE_WIDTH-1:0]     o_nonce,
    output logic [1:0]                 o_hash_type
);
    localparam int C_RES_W = RESULT_WORDS * 64;
    localparam int C_WC_W  = $clog2(MSG_WORDS + 1);
    localparam int C_RC_W  = $clog2(RESULT_WORDS + 1);
    localparam logic [C_WC_W-1:0] C_WORD_LAST = C_WC_W'(MSG_WORDS - 1);
    localparam logic [C_RC_W-1:0] C_RES_LAST  = C_RC_W'(RESULT_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COLLECT = 2'd2,
        S_OUT     = 2'd3
    } state_t;

    state_t                   state_q;
    logic                     buf_full_q;
    logic [STATE_WIDTH-1:0]   buf_state_q;
    logic [NONCE_WIDTH-1:0]   buf_nonce_q;
    logic [STATE_WIDTH-1:0]   act_state_q;
    logic [NONCE_WIDTH-1:0]   nonce_q;
    logic [1:0]               type_q;
    logic [C_WC_W-1:0]        word_cnt_q;
    logic [C_RC_W-1:0]        res_cnt_q;
    logic [C_RES_W-1:0]       result_q;

    logic [63:0]              w_msg_words [MSG_WORDS];
    logic [C_RES_W-1:0]       w_result_d;
    logic                     w_last_write;
    logic                     w_drop;
    logic                     w_take;

    function automatic logic [63:0] bswap64(input logic [63:0] w);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) begin
            r[8*b +: 8] = w[56-8*b +: 8];
        end
        return r;
    endfunction

    for (genvar g = 0; g < MSG_WORDS; g++) begin : g_msg_words
        assign w_msg_words[g] = bswap64(act_state_q[64*g +: 64]);
    end

    // The result register is byte-reversed as one vector, not word by word.
    for (genvar g = 0; g < RESULT_WORDS*8; g++) begin : g_result_rev
        assign o_result[8*g +: 8] = result_q[C_RES_W-8-8*g +: 8];
    end

    assign w_result_d   = (result_q << 64) | C_RES_W'(i_core_dout);
    assign w_last_write = (state_q == S_COLLECT) && i_core_dout_write
                          && (res_cnt_q == C_RES_LAST);

`ifdef POST_CN_TARGET_FILTER_EN
    // Top 64 bits of the reversed result come from the final core word.
    assign w_drop = (bswap64(i_core_dout) > i_target);
`else
    assign w_drop = 1'b0;
`endif

    assign w_take = buf_full_q && ((state_q == S_IDLE)
                                   || ((state_q == S_OUT) && i_ready)
                                   || (w_last_write && w_drop));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            buf_full_q <= 1'b0;
            type_q     <= 2'b00;
            nonce_q    <= '0;
            word_cnt_q <= '0;
            res_cnt_q  <= '0;
            result_q   <= '0;
        end else begin
            if (i_valid && !buf_full_q) begin
                buf_full_q <= 1'b1;
            end else if (w_take) begin
                buf_full_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                end
                S_LOAD: begin
                    if (i_core_din_read) begin
                        word_cnt_q <= word_cnt_q + C_WC_W'(1);
                        if (word_cnt_q == C_WORD_LAST) begin
                            state_q <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (i_core_dout_write) begin
                        result_q  <= w_result_d;
                        res_cnt_q <= res_cnt_q + C_RC_W'(1);
                        if (w_last_write) begin
                            state_q <= w_drop ? S_IDLE : S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (i_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // A job take overrides the per-state update, giving zero-bubble restart.
            if (w_take) begin
                state_q    <= S_LOAD;
                type_q     <= buf_state_q[1:0];
                nonce_q    <= buf_nonce_q;
                word_cnt_q <= '0;
                res_cnt_q  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_valid && !buf_full_q) begin
            buf_state_q <= i_state;
            buf_nonce_q <= i_nonce;
        end
        if (w_take) begin
            act_state_q <= buf_state_q;
        end
    end

`ifdef POST_CN_TARGET_FILTER_EN
    logic [31:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (w_last_write && w_drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    assign o_drop_count = drop_cnt_q;
`endif

    assign o_ready           = ~buf_full_q;
    assign o_hash_sel        = type_q;
    assign o_hash_type       = type_q;
    assign o_nonce           = nonce_q;
    assign o_core_din_valid  = (state_q == S_LOAD);
    assign o_core_dout_ready = (state_q == S_COLLECT);
    assign o_valid           = (state_q == S_OUT);
    assign o_core_din        = (state_q == S_LOAD) ? w_msg_words[word_cnt_q] : 64'd0;

endmodule
`default_nettype wire

// File: tb/tb_post_cn_hash_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_post_cn_hash_dispatch
// Brief    : Randomised and directed bench for post_cn_hash_dispatch against a
//            job-level reference model. Honours POST_CN_TARGET_FILTER_EN.
// Revision : 1.0
// ============================================================================
module tb_post_cn_hash_dispatch;
    localparam int SW    = 1600;
    localparam int NW    = 7;
    localparam int MW    = 25;
    localparam int RW    = 4;
    localparam int RES_W = RW * 64;
    localparam logic [RES_W-1:0] C_LIT_RES = {64'h0400000000000000, 64'h0300000000000000,
                                              64'h0200000000000000, 64'h0100000000000000};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [SW-1:0]    i_state = '0;
    logic [NW-1:0]    i_nonce = '0;
    logic [1:0]       o_hash_sel;
    logic [63:0]      o_core_din;
    logic             o_core_din_valid;
    logic             i_core_din_read = 1'b0;
    logic [63:0]      i_core_dout = '0;
    logic             i_core_dout_write = 1'b0;
    logic             o_core_dout_ready;
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic [RES_W-1:0] o_result;
    logic [NW-1:0]    o_nonce;
    logic [1:0]       o_hash_type;
`ifdef POST_CN_TARGET_FILTER_EN
    logic [63:0]      i_target = '1;
    logic [31:0]      o_drop_count;
`endif

    always #5 clk = ~clk;

    post_cn_hash_dispatch dut (
        .clk               (clk),
        .rst               (rst),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .i_state           (i_state),
        .i_nonce           (i_nonce),
        .o_hash_sel        (o_hash_sel),
        .o_core_din        (o_core_din),
        .o_core_din_valid  (o_core_din_valid),
        .i_core_din_read   (i_core_din_read),
        .i_core_dout       (i_core_dout),
        .i_core_dout_write (i_core_dout_write),
        .o_core_dout_ready (o_core_dout_ready),
`ifdef POST_CN_TARGET_FILTER_EN
        .i_target          (i_target),
        .o_drop_count      (o_drop_count),
`endif
        .o_valid           (o_valid),
        .i_ready           (i_ready),
        .o_result          (o_result),
        .o_nonce           (o_nonce),
        .o_hash_type       (o_hash_type)
    );

    int checks = 0;
    int errors = 0;
    int dut_reads = 0;
    int valid_seen = 0;

    // Inputs for the next cycle, applied right after the sampling edge
    logic          n_rst = 1'b1, n_valid = 1'b0, n_read = 1'b0, n_write = 1'b0;
    logic          n_ready = 1'b0, n_auto_dout = 1'b0;
    logic [SW-1:0] n_state = '0;
    logic [NW-1:0] n_nonce = '0;
    logic [63:0]   n_dout = '0;
    logic [63:0]   n_target = '1;

    // Job-level reference model
    bit               m_known = 0, m_active = 0, m_waiting = 0, m_res_zero = 0;
    logic [SW-1:0]    m_state = '0, m_wstate = '0;
    logic [NW-1:0]    m_nonce = '0, m_wnonce = '0;
    logic [1:0]       m_type = '0;
    int               m_sent = 0, m_recv = 0;
    logic [RES_W-1:0] m_acc = '0, m_result = '0;
    logic [31:0]      m_drops = '0;

    function automatic logic [63:0] bswap64(input logic [63:0] w);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = w[56-8*b +: 8];
        return r;
    endfunction

    function automatic logic [RES_W-1:0] byte_rev(input logic [RES_W-1:0] v);
        logic [RES_W-1:0] r;
        for (int b = 0; b < RES_W/8; b++) r[8*b +: 8] = v[RES_W-8-8*b +: 8];
        return r;
    endfunction

    function automatic logic [SW-1:0] rand_state();
        logic [SW-1:0] s;
        for (int i = 0; i < SW/32; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic chk(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare();
        bit din_v, out_v;
        din_v = m_active && (m_sent < MW);
        out_v = m_active && (m_recv == RW);
        chk("o_ready", o_ready, !m_waiting);
        chk("o_core_din_valid", o_core_din_valid, din_v);
        if (din_v) chk("o_core_din", o_core_din, bswap64(m_state[64*m_sent +: 64]));
        chk("o_core_dout_ready", o_core_dout_ready, m_active && (m_sent == MW) && (m_recv < RW));
        chk("o_valid", o_valid, out_v);
        if (out_v) chk("o_result", o_result, m_result);
        else if (m_res_zero) chk("o_result_reset", o_result, '0);
        chk("o_hash_sel", o_hash_sel, m_type);
        chk("o_hash_type", o_hash_type, m_type);
        chk("o_nonce", o_nonce, m_nonce);
`ifdef POST_CN_TARGET_FILTER_EN
        chk("o_drop_count", o_drop_count, m_drops);
`endif
    endtask

    task automatic model_update();
        bit acc, rd, wr, hs, ended, was_active;
        if (rst) begin
            m_known = 1; m_active = 0; m_waiting = 0; m_type = '0; m_nonce = '0;
            m_res_zero = 1; m_drops = '0;
            return;
        end
        if (!m_known) return;
        acc = i_valid && !m_waiting;
        rd  = m_active && (m_sent < MW) && i_core_din_read;
        wr  = m_active && (m_sent == MW) && (m_recv < RW) && i_core_dout_write;
        hs  = m_active && (m_recv == RW) && i_ready;
        was_active = m_active;
        ended = 0;
        if (rd) m_sent++;
        if (wr) begin
            m_res_zero = 0;
            m_acc = (m_acc << 64) | RES_W'(i_core_dout);
            m_recv++;
            if (m_recv == RW) begin
                m_result = byte_rev(m_acc);
`ifdef POST_CN_TARGET_FILTER_EN
                if (m_result[RES_W-1 -: 64] > i_target) begin
                    ended = 1;
                    m_active = 0;
                    if (m_drops != 32'hFFFF_FFFF) m_drops++;
                end
`endif
            end
        end
        if (hs) begin
            ended = 1;
            m_active = 0;
        end
        if (m_waiting && (!was_active || ended)) begin
            m_waiting = 0; m_active = 1; m_sent = 0; m_recv = 0;
            m_state = m_wstate; m_nonce = m_wnonce; m_type = m_wstate[1:0];
        end
        if (acc) begin
            m_waiting = 1; m_wstate = i_state; m_wnonce = i_nonce;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (m_known) compare();
        rst               = n_rst;
        i_valid           = n_valid;
        i_state           = n_state;
        i_nonce           = n_nonce;
        i_core_din_read   = n_read;
        i_core_dout_write = n_write;
        i_core_dout       = n_auto_dout ? 64'(m_recv + 1) : n_dout;
        i_ready           = n_ready;
`ifdef POST_CN_TARGET_FILTER_EN
        i_target          = n_target;
`endif
        if (o_core_din_valid && i_core_din_read) dut_reads++;
        if (o_valid) valid_seen++;
        model_update();
    endtask

    task automatic wait_valid(input int bound);
        for (int k = 0; k < bound && !o_valid; k++) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick(); tick();
        n_rst = 1'b0;
        tick();
        chk("reset_ready", o_ready, 1'b1);
        chk("reset_valid", o_valid, 1'b0);

        // Single job: type 10, nonce 15, words 1..4
        n_valid = 1'b1; n_state = rand_state(); n_state[63:0] = 64'h0123456789ABCDEE;
        n_nonce = 7'h15; n_read = 1'b1; n_write = 1'b1; n_auto_dout = 1'b1; n_ready = 1'b0;
        dut_reads = 0;
        tick();
        chk("t1_accept_ready", o_ready, 1'b1);
        n_valid = 1'b0;
        tick();
        chk("t1_latency_t1", o_core_din_valid, 1'b0);
        tick();
        chk("t1_latency_t2", o_core_din_valid, 1'b1);
        chk("t1_word0", o_core_din, 64'hEECDAB8967452301);
        chk("t1_hash_sel", o_hash_sel, 2'b10);
        wait_valid(80);
        chk("t1_valid", o_valid, 1'b1);
        chk("t1_reads", dut_reads, 25);
        chk("t1_result", o_result, C_LIT_RES);
        chk("t1_nonce", o_nonce, 7'h15);
        chk("t1_type", o_hash_type, 2'b10);
        // Stall in OUT with stray core writes
        n_auto_dout = 1'b0;
        for (int c = 0; c < 10; c++) begin
            n_dout = {$urandom, $urandom};
            tick();
            chk("t1_hold_valid", o_valid, 1'b1);
            chk("t1_hold_result", o_result, C_LIT_RES);
        end
        n_ready = 1'b1;
        tick();
        n_ready = 1'b0;
        tick();
        chk("t1_released", o_valid, 1'b0);

        // Back-to-back jobs A (00) then B (11) presented during A's LOAD
        n_ready = 1'b1; n_write = 1'b1; n_auto_dout = 1'b0;
        n_valid = 1'b1; n_state = rand_state(); n_state[1:0] = 2'b00; n_nonce = 7'h21;
        tick();
        n_valid = 1'b0;
        for (int k = 0; k < 10 && !o_core_din_valid; k++) tick();
        n_valid = 1'b1; n_state = rand_state(); n_state[1:0] = 2'b11; n_nonce = 7'h5A;
        tick();
        chk("t2_b_accept", o_ready, 1'b1);
        chk("t2_sel_a_load", o_hash_sel, 2'b00);
        n_valid = 1'b0;
        wait_valid(80);
        chk("t2_a_valid", o_valid, 1'b1);
        chk("t2_sel_a_out", o_hash_sel, 2'b00);
        tick();
        chk("t2_sel_b", o_hash_sel, 2'b11);
        chk("t2_no_bubble", o_core_din_valid, 1'b1);
        wait_valid(80);
        tick();

        // Throttled reads, every third cycle
        dut_reads = 0;
        n_valid = 1'b1; n_state = rand_state(); n_nonce = $urandom;
        for (int c = 0; c < 300 && !o_valid; c++) begin
            n_read = (c % 3 == 0);
            n_dout = {$urandom, $urandom};
            tick();
            n_valid = 1'b0;
        end
        chk("t3_valid", o_valid, 1'b1);
        chk("t3_reads", dut_reads, 25);
        n_read = 1'b1;
        tick();

        // Reset in the middle of COLLECT after two words
        n_ready = 1'b0; n_auto_dout = 1'b1;
        n_valid = 1'b1; n_state = rand_state(); n_nonce = $urandom;
        tick();
        n_valid = 1'b0;
        for (int k = 0; k < 100 && !(m_active && m_sent == MW && m_recv == 2); k++) tick();
        n_write = 1'b0; n_rst = 1'b1;
        tick();
        n_rst = 1'b0; n_write = 1'b1;
        tick();
        chk("t4_rst_dout_ready", o_core_dout_ready, 1'b0);
        chk("t4_rst_result", o_result, '0);
        chk("t4_rst_sel", o_hash_sel, 2'b00);
        n_valid = 1'b1; n_state = rand_state(); n_nonce = 7'h33;
        tick();
        n_valid = 1'b0;
        wait_valid(80);
        chk("t4_result", o_result, C_LIT_RES);
        n_ready = 1'b1;
        tick();

`ifdef POST_CN_TARGET_FILTER_EN
        // Target 0 drops a nonzero result; buffered job starts at once
        n_rst = 1'b1; tick(); n_rst = 1'b0;
        n_target = '0; valid_seen = 0;
        n_valid = 1'b1; n_state = rand_state(); n_state[1:0] = 2'b01;
        tick();
        n_valid = 1'b0;
        for (int k = 0; k < 10 && !o_core_din_valid; k++) tick();
        n_valid = 1'b1; n_state = rand_state(); n_state[1:0] = 2'b10;
        tick();
        n_valid = 1'b0;
        for (int k = 0; k < 80 && o_drop_count == 0; k++) tick();
        chk("tf_drop_count", o_drop_count, 32'd1);
        chk("tf_no_valid", valid_seen, 0);
        chk("tf_next_load", o_core_din_valid, 1'b1);
        chk("tf_next_sel", o_hash_sel, 2'b10);
        n_target = '1;
        wait_valid(80);
        tick();
`endif

        // Randomised traffic
        n_auto_dout = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            n_rst   = ($urandom_range(0, 599) == 0);
            n_valid = ($urandom_range(0, 3) == 0);
            n_state = rand_state();
            n_nonce = $urandom;
            n_read  = ($urandom_range(0, 2) != 0);
            n_write = ($urandom_range(0, 1) == 1);
            n_dout  = {$urandom, $urandom};
            n_ready = ($urandom_range(0, 3) != 0);
            n_target = ($urandom_range(0, 1) == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            tick();
        end
        n_rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/post_cn_hash_dispatch.md
Name: post_cn_hash_dispatch

Overview:
- Parametrised successor to the post-CryptoNight finalist stage.
- Accepts a Keccak-permuted state tagged with its nonce, and selects the finalist hash from state[1:0].
- Streams the state as byte-reversed 64-bit words into the selected core, collects RESULT_WORDS output words, and emits result, nonce and hash type together on one ready/valid port.
- A one-entry input buffer lets the next job be accepted while the current job is in flight.

Parameters:
- STATE_WIDTH, 1600, width of the incoming Keccak state.
- NONCE_WIDTH, 7, width of the nonce tag carried with each job.
- MSG_WORDS, 25, number of 64-bit words streamed to the core; MSG_WORDS*64 <= STATE_WIDTH.
- RESULT_WORDS, 4, number of 64-bit words collected from the core; result width is RESULT_WORDS*64.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input job valid.
- o_ready  out  1  input buffer empty, job can be accepted.
- i_state  in  STATE_WIDTH  Keccak state.
- i_nonce  in  NONCE_WIDTH  nonce tag.
- o_hash_sel  out  2  finalist select of the active job: 00 blake, 01 groestl, 10 JH, 11 skein.
- o_core_din  out  64  message word to the core.
- o_core_din_valid  out  1  message word valid.
- i_core_din_read  in  1  core consumes o_core_din this cycle.
- i_core_dout  in  64  result word from the core.
- i_core_dout_write  in  1  result word valid.
- o_core_dout_ready  out  1  block accepts a result word.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_result  out  RESULT_WORDS*64  hash result.
- o_nonce  out  NONCE_WIDTH  nonce of the result.
- o_hash_type  out  2  hash type of the result.

Behaviour:
- Reset: all of the following are 0 after reset, and the buffer is empty with FSM in IDLE.
  - o_valid, o_core_din_valid, o_core_dout_ready, o_hash_sel, o_result, o_nonce, o_hash_type.
  - o_ready is 1.
  - A reset mid-job abandons the job silently; no partial result is ever emitted.
- Input buffer:
  - o_ready = ~buf_full.
  - i_valid && o_ready captures {i_nonce, i_state} and sets buf_full.
  - buf_full clears in the cycle the FSM takes the job. o_ready is 1 in the following cycle, so a new job can be accepted while the FSM is busy.
- FSM states: IDLE, LOAD, COLLECT, OUT.
  - IDLE: if buf_full, take the job into active registers.
    - Capture hash type = state[1:0] (drives o_hash_sel) and the nonce.
    - Clear word counter and result counter; next state LOAD.
    - A job accepted at cycle t with the FSM idle enters LOAD at t+2.
  - LOAD: o_core_din_valid = 1.
    - o_core_din = byte-reversed active_state[64*k +: 64], where k is the word counter, 0..MSG_WORDS-1.
    - k increments on i_core_din_read.
    - A read with k == MSG_WORDS-1 moves to COLLECT.
  - COLLECT: o_core_dout_ready = 1.
    - On i_core_dout_write, shift the result register left by 64 and insert i_core_dout in the low word; increment the result counter.
    - The write that makes the count RESULT_WORDS moves to OUT; the first collected word ends up most significant.
    - i_core_dout_write outside COLLECT is ignored.
  - OUT: o_valid = 1.
    - o_result = byte-reversal of the full RESULT_WORDS*64 register, reversed as one vector.
    - o_nonce and o_hash_type hold the active job's values.
    - o_valid, o_result, o_nonce and o_hash_type are stable while i_ready is low.
    - On i_ready: if buf_full, take the next job the same cycle (zero bubble, next state LOAD); else go to IDLE.
- o_hash_sel changes only when a job is taken, never during LOAD, COLLECT or OUT.
- Counters are sized $clog2(MSG_WORDS+1) and $clog2(RESULT_WORDS+1); they never wrap.

Optional Feature:
- Macro: POST_CN_TARGET_FILTER_EN.
- When defined:
  - Adds port i_target (in, 64), the share target, sampled in the cycle the COLLECT-to-OUT transition occurs.
  - Adds port o_drop_count (out, 32, reset 0).
  - If o_result[RESULT_WORDS*64-1 -: 64] > i_target (unsigned), the job is dropped: o_valid never rises, and the FSM goes to LOAD if buf_full, else IDLE.
  - o_drop_count increments on each drop and saturates at 32'hFFFFFFFF.
- When undefined: the ports are absent and every result is forwarded.

Test Plan:
- Single job, hash type 2'b10, nonce 7'h15, core reads every cycle and writes 4 words 1,2,3,4 -> o_hash_sel = 10 from job start; exactly 25 reads; o_core_din word 0 = byte-reversed i_state[63:0]; o_valid with o_result = byte-reversal of {64'd1, 64'd2, 64'd3, 64'd4}, o_nonce = 7'h15, o_hash_type = 2'b10.
- Back-to-back jobs A (type 00) and B (type 11), B presented while A is in LOAD -> B accepted (o_ready = 1); o_hash_sel stays 00 until A's OUT handshake, then 11 with no idle cycle.
- i_ready held low 10 cycles in OUT -> o_valid and o_result stable; o_core_dout_ready = 0; extra i_core_dout_write pulses ignored.
- Core read throttled every 3rd cycle -> word order 0..24 preserved, no word skipped or repeated.
- rst asserted mid-COLLECT after 2 result words -> next cycle all outputs at reset values; the next job produces a correct result unpolluted by stale words.
- With POST_CN_TARGET_FILTER_EN, i_target = 0 and a nonzero result -> no o_valid; o_drop_count = 1; the buffered next job starts immediately.
